// File: rtl/wb_pipe.sv
// wb_pipe: memory-access / writeback pipeline for the RISC-V core.
// Carries each instruction through DMEM_LAT stages while DMEM answers the
// load, extends and lane-aligns the load data, picks the writeback source
// and drives a registered register-file write port.
// Optional feature macro: WB_MISALIGN_TRAP_EN adds misalign_trap/misalign_pc
// and suppresses the register write of misaligned loads. Without it the load
// offset is rounded down to the access size and the load writes normally.
module wb_pipe #(
  parameter int DWIDTH   = 32,
  parameter int DMEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_pc,
  input  logic [DWIDTH-1:0] in_alu_out,
  input  logic [4:0]        in_rd,
  input  logic              in_regwen,
  input  logic [2:0]        in_ldsel,
  input  logic [1:0]        in_wbsel,
  input  logic [DWIDTH-1:0] dmem_dout,
  input  logic [4:0]        hazard_rd,
  output logic              hazard,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata
`ifdef WB_MISALIGN_TRAP_EN
  ,
  output logic              misalign_trap,
  output logic [DWIDTH-1:0] misalign_pc
`endif
);

  localparam int OFFW = (DWIDTH == 64) ? 3 : 2;
  localparam int LAST = DMEM_LAT - 1;

  logic [DMEM_LAT-1:0] r_valid;
  logic [DWIDTH-1:0]   r_pc     [DMEM_LAT];
  logic [DWIDTH-1:0]   r_alu    [DMEM_LAT];
  logic [4:0]          r_rd     [DMEM_LAT];
  logic                r_regwen [DMEM_LAT];
  logic [2:0]          r_ldsel  [DMEM_LAT];
  logic [1:0]          r_wbsel  [DMEM_LAT];

  logic              r_rfWe;
  logic [4:0]        r_rfWaddr;
  logic [DWIDTH-1:0] r_rfWdata;

  logic [OFFW-1:0]   w_offset;
  logic [OFFW-1:0]   w_halfOff;
  logic [OFFW-1:0]   w_wordOff;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [DWIDTH-1:0] w_loadData;
  logic [DWIDTH-1:0] w_wbData;
  logic              w_wbWe;
  logic              w_wbWeFinal;

  assign w_offset  = r_alu[LAST][OFFW-1:0];
  assign w_halfOff = w_offset & ~OFFW'(1);
  assign w_wordOff = w_offset & ~OFFW'(3);

  // Stage valids: flush and reset kill everything, otherwise shift on advance
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid <= '0;
    end else if (!stall) begin
      r_valid[0] <= in_valid;
      for (int i = 1; i < DMEM_LAT; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  // Stage payload needs no reset; it is only meaningful alongside its valid
  always_ff @(posedge clk) begin
    if (!stall) begin
      r_pc[0]     <= in_pc;
      r_alu[0]    <= in_alu_out;
      r_rd[0]     <= in_rd;
      r_regwen[0] <= in_regwen;
      r_ldsel[0]  <= in_ldsel;
      r_wbsel[0]  <= in_wbsel;
      for (int i = 1; i < DMEM_LAT; i++) begin
        r_pc[i]     <= r_pc[i-1];
        r_alu[i]    <= r_alu[i-1];
        r_rd[i]     <= r_rd[i-1];
        r_regwen[i] <= r_regwen[i-1];
        r_ldsel[i]  <= r_ldsel[i-1];
        r_wbsel[i]  <= r_wbsel[i-1];
      end
    end
  end

  // Lane extraction: offset rounded down to the access size picks the lane
  always_comb begin
    w_byte = 8'(dmem_dout >> {w_offset, 3'b000});
    w_half = 16'(dmem_dout >> {w_halfOff, 3'b000});
    w_word = 32'(dmem_dout >> {w_wordOff, 3'b000});
  end

  // Sign/zero extension; on a 32-bit datapath LD and LWU collapse to LW
  always_comb begin
    w_loadData = '0;
    case (r_ldsel[LAST])
      3'd0:    w_loadData = DWIDTH'($signed(w_byte));
      3'd1:    w_loadData = DWIDTH'($signed(w_half));
      3'd2:    w_loadData = DWIDTH'($signed(w_word));
      3'd3:    w_loadData = (DWIDTH == 64) ? dmem_dout : DWIDTH'($signed(w_word));
      3'd4:    w_loadData = DWIDTH'(w_byte);
      3'd5:    w_loadData = DWIDTH'(w_half);
      3'd6:    w_loadData = DWIDTH'(w_word);
      default: w_loadData = '0;
    endcase
  end

  // Writeback source select and write-enable qualification
  always_comb begin
    w_wbData = '0;
    case (r_wbsel[LAST])
      2'd0:    w_wbData = r_alu[LAST];
      2'd1:    w_wbData = w_loadData;
      2'd2:    w_wbData = r_pc[LAST] + DWIDTH'(4);
      default: w_wbData = '0;
    endcase
    w_wbWe = r_valid[LAST] && r_regwen[LAST] && (r_rd[LAST] != 5'd0) &&
             (r_wbsel[LAST] != 2'd3);
  end

`ifdef WB_MISALIGN_TRAP_EN
  logic w_misalign;

  // A DMEM load whose offset is not a multiple of its access size traps
  always_comb begin
    w_misalign = 1'b0;
    if (r_valid[LAST] && (r_wbsel[LAST] == 2'd1)) begin
      case (r_ldsel[LAST])
        3'd1, 3'd5: w_misalign = w_offset[0];
        3'd2, 3'd6: w_misalign = |w_offset[1:0];
        3'd3:       w_misalign = |w_offset;
        default:    w_misalign = 1'b0;
      endcase
    end
  end

  assign w_wbWeFinal = w_wbWe && !w_misalign;

  // Trap pulse is registered alongside rf_* so it lines up with the write slot
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_trap <= 1'b0;
      misalign_pc   <= '0;
    end else if (flush) begin
      misalign_trap <= 1'b0;
    end else if (!stall) begin
      misalign_trap <= w_misalign;
      if (w_misalign) misalign_pc <= r_pc[LAST];
    end
  end
`else
  assign w_wbWeFinal = w_wbWe;
`endif

  // Registered write port; a held write during stall is a harmless rewrite
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rfWe    <= 1'b0;
      r_rfWaddr <= '0;
      r_rfWdata <= '0;
    end else if (flush) begin
      r_rfWe <= 1'b0;
    end else if (!stall) begin
      r_rfWe    <= w_wbWeFinal;
      r_rfWaddr <= r_rd[LAST];
      r_rfWdata <= w_wbData;
    end
  end

  // Decode-side RAW query over every in-flight stage (x0 never hazards)
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DMEM_LAT; i++) begin
      if (r_valid[i] && r_regwen[i] && (r_rd[i] == hazard_rd) && (r_rd[i] != 5'd0))
        hazard = 1'b1;
    end
  end

  assign rf_we    = r_rfWe;
  assign rf_waddr = r_rfWaddr;
  assign rf_wdata = r_rfWdata;

endmodule

// File: tb/tb_wb_pipe.sv
// Testbench for wb_pipe: a 32-bit / DMEM_LAT=3 instance checked against a
// queue-based reference model, plus a 64-bit / DMEM_LAT=1 instance checked
// against hand-computed load results.
module tb_wb_pipe;
  localparam int LAT = 3;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        regwen;
    logic [2:0]  ldsel;
    logic [1:0]  wbsel;
  } entry_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, inValid, inRegwen;
  logic [31:0] inPc, inAlu, dmemDout, rfWdata;
  logic [4:0]  inRd, hazardRd, rfWaddr;
  logic [2:0]  inLdsel;
  logic [1:0]  inWbsel;
  logic        hazard, rfWe;
`ifdef WB_MISALIGN_TRAP_EN
  logic        trap;
  logic [31:0] trapPc;
  logic        expTrap;
  logic [31:0] expTrapPc;
  logic        d64Trap;
  logic [63:0] d64TrapPc;
`endif

  logic        d64Rst, d64Stall, d64Flush, d64Valid, d64Regwen, d64Hazard, d64We;
  logic [63:0] d64Pc, d64Alu, d64Dout, d64Wdata;
  logic [4:0]  d64Rd, d64HazardRd, d64Waddr;
  logic [2:0]  d64Ldsel;
  logic [1:0]  d64Wbsel;

  int testsRun = 0;
  int testsFailed = 0;

  entry_t      pipeQ[$];
  logic        expWe, expWbValid;
  logic [4:0]  expWaddr;
  logic [31:0] expWdata;

  wb_pipe #(.DWIDTH(32), .DMEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(inValid), .in_pc(inPc), .in_alu_out(inAlu), .in_rd(inRd),
    .in_regwen(inRegwen), .in_ldsel(inLdsel), .in_wbsel(inWbsel),
    .dmem_dout(dmemDout), .hazard_rd(hazardRd), .hazard(hazard),
    .rf_we(rfWe), .rf_waddr(rfWaddr), .rf_wdata(rfWdata)
`ifdef WB_MISALIGN_TRAP_EN
    , .misalign_trap(trap), .misalign_pc(trapPc)
`endif
  );

  wb_pipe #(.DWIDTH(64), .DMEM_LAT(1)) u64 (
    .clk(clk), .rst(d64Rst), .stall(d64Stall), .flush(d64Flush),
    .in_valid(d64Valid), .in_pc(d64Pc), .in_alu_out(d64Alu), .in_rd(d64Rd),
    .in_regwen(d64Regwen), .in_ldsel(d64Ldsel), .in_wbsel(d64Wbsel),
    .dmem_dout(d64Dout), .hazard_rd(d64HazardRd), .hazard(d64Hazard),
    .rf_we(d64We), .rf_waddr(d64Waddr), .rf_wdata(d64Wdata)
`ifdef WB_MISALIGN_TRAP_EN
    , .misalign_trap(d64Trap), .misalign_pc(d64TrapPc)
`endif
  );

  // Reference helpers: load result from the architectural rules
  function automatic logic [31:0] refLoad(input logic [2:0] ldsel, input logic [31:0] addr,
                                          input logic [31:0] dout);
    int off;
    logic [31:0] v;
    off = int'(addr % 4);
    case (ldsel)
      3'd0, 3'd4: begin
        v = (dout >> (8 * off)) & 32'hFF;
        if (ldsel == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
        return v;
      end
      3'd1, 3'd5: begin
        off = off - (off % 2);
        v = (dout >> (8 * off)) & 32'hFFFF;
        if (ldsel == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
        return v;
      end
      3'd2, 3'd3, 3'd6: return dout;
      default: return 32'h0;
    endcase
  endfunction

`ifdef WB_MISALIGN_TRAP_EN
  function automatic logic isMisaligned(input logic [2:0] ldsel, input logic [31:0] addr);
    if (ldsel == 3'd1 || ldsel == 3'd5) return (addr % 2) != 0;
    if (ldsel == 3'd2 || ldsel == 3'd3 || ldsel == 3'd6) return (addr % 4) != 0;
    return 1'b0;
  endfunction
`endif

  function automatic logic refHazard(input logic [4:0] q);
    foreach (pipeQ[i])
      if (pipeQ[i].valid && pipeQ[i].regwen && pipeQ[i].rd == q && q != 5'd0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic entry_t mkEntry(input logic [31:0] pc, input logic [31:0] alu,
                                     input logic [4:0] rd, input logic [2:0] ldsel,
                                     input logic [1:0] wbsel);
    entry_t e;
    e.valid = 1'b1; e.pc = pc; e.alu = alu; e.rd = rd; e.regwen = 1'b1;
    e.ldsel = ldsel; e.wbsel = wbsel;
    return e;
  endfunction

  function automatic entry_t bubble();
    return '0;
  endfunction

  // Drive one cycle of inputs, clock it, and advance the reference model
  task automatic applyStimulus(input entry_t e, input logic stallV, input logic flushV,
                               input logic rstV, input logic [31:0] dout);
    entry_t old;
    logic [31:0] data;
    inValid = e.valid; inPc = e.pc; inAlu = e.alu; inRd = e.rd; inRegwen = e.regwen;
    inLdsel = e.ldsel; inWbsel = e.wbsel;
    stall = stallV; flush = flushV; rst = rstV; dmemDout = dout;
    @(posedge clk);
    if (rstV) begin
      pipeQ.delete();
      for (int i = 0; i < LAT; i++) pipeQ.push_back(bubble());
      expWe = 1'b0; expWaddr = 5'd0; expWdata = 32'h0; expWbValid = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      expTrap = 1'b0; expTrapPc = 32'h0;
`endif
    end else if (flushV) begin
      foreach (pipeQ[i]) pipeQ[i].valid = 1'b0;
      expWe = 1'b0; expWbValid = 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
      expTrap = 1'b0;
`endif
    end else if (!stallV) begin
      old = pipeQ[LAT-1];
      case (old.wbsel)
        2'd0:    data = old.alu;
        2'd1:    data = refLoad(old.ldsel, old.alu, dout);
        2'd2:    data = old.pc + 32'd4;
        default: data = 32'h0;
      endcase
      expWe = old.valid && old.regwen && old.rd != 5'd0 && old.wbsel != 2'd3;
`ifdef WB_MISALIGN_TRAP_EN
      expTrap = old.valid && old.wbsel == 2'd1 && isMisaligned(old.ldsel, old.alu);
      if (expTrap) begin
        expWe = 1'b0;
        expTrapPc = old.pc;
      end
`endif
      expWaddr = old.rd; expWdata = data;
      expWbValid = old.valid && old.wbsel != 2'd3;
      void'(pipeQ.pop_back());
      pipeQ.push_front(e);
    end
    #1;
  endtask

  task automatic test_reset();
    entry_t e;
    hazardRd = 5'd5;
    applyStimulus(mkEntry(32'h10, 32'h20, 5'd5, 3'd2, 2'd0), 1'b0, 1'b0, 1'b1, 32'h0);
    testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_we: got %b expected 0", rfWe); end
    testsRun++; if (rfWaddr !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_waddr: got %0d expected 0", rfWaddr); end
    testsRun++; if (rfWdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_wdata: got %h expected 0", rfWdata); end
    testsRun++; if (hazard !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_hazard: got %b expected 0", hazard); end
`ifdef WB_MISALIGN_TRAP_EN
    testsRun++; if (trap !== 1'b0 || trapPc !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_trap: got %b/%h expected 0/0", trap, trapPc); end
`endif
    // Fill with writers of x12, then reset mid-stream
    hazardRd = 5'd12;
    for (int i = 0; i < LAT; i++)
      applyStimulus(mkEntry(32'h100, 32'h55, 5'd12, 3'd0, 2'd0), 1'b0, 1'b0, 1'b0, 32'h0);
    testsRun++; if (hazard !== 1'b1) begin testsFailed++; $display("[TB] FAIL prefill_hazard: got %b expected 1", hazard); end
    applyStimulus(bubble(), 1'b0, 1'b0, 1'b1, 32'h0);
    testsRun++; if (hazard !== 1'b0 || rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset: got hazard %b we %b expected 0 0", hazard, rfWe); end
    e = mkEntry(32'h200, 32'h77, 5'd13, 3'd0, 2'd0);
    applyStimulus(e, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < LAT; i++) begin
      applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h0);
      if (i == LAT - 1) begin
        testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd13 || rfWdata !== 32'h77) begin testsFailed++; $display("[TB] FAIL post_reset_write: got %b %0d %h expected 1 13 00000077", rfWe, rfWaddr, rfWdata); end
      end else begin
        testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_reset_early: got %b expected 0", rfWe); end
      end
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]  sels[2] = '{3'd0, 3'd4};
    logic [31:0] exps[2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i <= LAT; i++) applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h80FF_1234);
      applyStimulus(mkEntry(32'h2000, 32'h1003, 5'd4, sels[k], 2'd1), 1'b0, 1'b0, 1'b0, 32'h80FF_1234);
      for (int i = 1; i < LAT; i++) applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h80FF_1234);
      testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL load_early_%0d: got %b expected 0", k, rfWe); end
      applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h80FF_1234);
      testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd4 || rfWdata !== exps[k]) begin testsFailed++; $display("[TB] FAIL load_ext_%0d: got %b %0d %h expected 1 4 %h", k, rfWe, rfWaddr, rfWdata, exps[k]); end
    end
  endtask

  task automatic test_back_to_back();
    entry_t e;
    logic expH;
    for (int i = 0; i <= LAT; i++) applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h0);
    hazardRd = 5'd6;
    for (int c = 1; c <= LAT + 4; c++) begin
      if (c == 1) e = mkEntry(32'h0F0, 32'h11, 5'd5, 3'd0, 2'd0);
      else if (c == 2) e = mkEntry(32'h0F4, 32'h3002, 5'd6, 3'd1, 2'd1);
      else if (c == 3) e = mkEntry(32'h100, 32'h999, 5'd1, 3'd0, 2'd2);
      else e = bubble();
      applyStimulus(e, 1'b0, 1'b0, 1'b0, 32'hBEEF_0000);
      expH = (c >= 2) && (c <= LAT + 1);
      testsRun++; if (hazard !== expH) begin testsFailed++; $display("[TB] FAIL b2b_hazard_c%0d: got %b expected %b", c, hazard, expH); end
      if (c == LAT + 1) begin
        testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd5 || rfWdata !== 32'h11) begin testsFailed++; $display("[TB] FAIL b2b_alu: got %b %0d %h expected 1 5 00000011", rfWe, rfWaddr, rfWdata); end
      end else if (c == LAT + 2) begin
        testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd6 || rfWdata !== 32'hFFFF_BEEF) begin testsFailed++; $display("[TB] FAIL b2b_lh: got %b %0d %h expected 1 6 ffffbeef", rfWe, rfWaddr, rfWdata); end
      end else if (c == LAT + 3) begin
        testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd1 || rfWdata !== 32'h104) begin testsFailed++; $display("[TB] FAIL b2b_jal: got %b %0d %h expected 1 1 00000104", rfWe, rfWaddr, rfWdata); end
      end else begin
        testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_idle_c%0d: got %b expected 0", c, rfWe); end
      end
    end
  endtask

  task automatic test_stall_flush();
    entry_t other;
    other = mkEntry(32'h500, 32'h66, 5'd20, 3'd0, 2'd0);
    for (int i = 0; i <= LAT; i++) applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    hazardRd = 5'd7;
    applyStimulus(mkEntry(32'h300, 32'h204, 5'd7, 3'd2, 2'd1), 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    for (int i = 1; i < LAT; i++) applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    for (int s = 0; s < 2; s++) begin
      applyStimulus(other, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
      testsRun++; if (rfWe !== 1'b0 || hazard !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_hold_%0d: got we %b hazard %b expected 0 1", s, rfWe, hazard); end
    end
    applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd7 || rfWdata !== 32'h1234_5678) begin testsFailed++; $display("[TB] FAIL stall_release: got %b %0d %h expected 1 7 12345678", rfWe, rfWaddr, rfWdata); end
    applyStimulus(other, 1'b1, 1'b0, 1'b0, 32'h0);
    testsRun++; if (rfWe !== 1'b1 || rfWdata !== 32'h1234_5678) begin testsFailed++; $display("[TB] FAIL stall_we_held: got %b %h expected 1 12345678", rfWe, rfWdata); end
    applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h0);
    testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_single_write: got %b expected 0", rfWe); end
    // Flush while stalled must still kill the in-flight entries
    hazardRd = 5'd10;
    for (int i = 0; i < LAT; i++)
      applyStimulus(mkEntry(32'h600, 32'h1 + i, 5'd10, 3'd0, 2'd0), 1'b0, 1'b0, 1'b0, 32'h0);
    testsRun++; if (hazard !== 1'b1) begin testsFailed++; $display("[TB] FAIL preflush_hazard: got %b expected 1", hazard); end
    applyStimulus(other, 1'b1, 1'b1, 1'b0, 32'h0);
    testsRun++; if (rfWe !== 1'b0 || hazard !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_stall: got we %b hazard %b expected 0 0", rfWe, hazard); end
    for (int i = 0; i <= LAT; i++) begin
      applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'h0);
      testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_drain_%0d: got %b expected 0", i, rfWe); end
    end
  endtask

  task automatic test_corner();
    entry_t e;
    for (int i = 0; i <= LAT; i++) applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    hazardRd = 5'd0;
    for (int c = 1; c <= LAT + 4; c++) begin
      if (c == 1) e = mkEntry(32'h10, 32'h55, 5'd0, 3'd0, 2'd0);
      else if (c == 2) e = mkEntry(32'h14, 32'h56, 5'd8, 3'd0, 2'd3);
      else if (c == 3) e = mkEntry(32'hFFFF_FFFC, 32'h57, 5'd3, 3'd0, 2'd2);
      else if (c == 4) e = mkEntry(32'h18, 32'h100, 5'd9, 3'd7, 2'd1);
      else e = bubble();
      applyStimulus(e, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
      if (c == 1) begin
        testsRun++; if (hazard !== 1'b0) begin testsFailed++; $display("[TB] FAIL hazard_x0: got %b expected 0", hazard); end
      end
      if (c == LAT + 1 || c == LAT + 2) begin
        testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL no_write_c%0d: got %b expected 0", c, rfWe); end
      end else if (c == LAT + 3) begin
        testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd3 || rfWdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL pc_wrap: got %b %0d %h expected 1 3 00000000", rfWe, rfWaddr, rfWdata); end
      end else if (c == LAT + 4) begin
        testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd9 || rfWdata !== 32'h0) begin testsFailed++; $display("[TB] FAIL ldsel7: got %b %0d %h expected 1 9 00000000", rfWe, rfWaddr, rfWdata); end
      end
    end
  endtask

  task automatic test_misalign();
    for (int i = 0; i <= LAT; i++) applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'hA1B2_C3D4);
    applyStimulus(mkEntry(32'h40, 32'h42, 5'd9, 3'd2, 2'd1), 1'b0, 1'b0, 1'b0, 32'hA1B2_C3D4);
    applyStimulus(mkEntry(32'h44, 32'h101, 5'd11, 3'd1, 2'd1), 1'b0, 1'b0, 1'b0, 32'hA1B2_C3D4);
    for (int i = 2; i < LAT; i++) applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'hA1B2_C3D4);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(bubble(), 1'b0, 1'b0, 1'b0, 32'hA1B2_C3D4);
`ifdef WB_MISALIGN_TRAP_EN
      testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL trap_we_c%0d: got %b expected 0", c, rfWe); end
      if (c == 0) begin
        testsRun++; if (trap !== 1'b1 || trapPc !== 32'h40) begin testsFailed++; $display("[TB] FAIL trap_lw: got %b %h expected 1 00000040", trap, trapPc); end
      end else if (c == 1) begin
        testsRun++; if (trap !== 1'b1 || trapPc !== 32'h44) begin testsFailed++; $display("[TB] FAIL trap_lh: got %b %h expected 1 00000044", trap, trapPc); end
      end else begin
        testsRun++; if (trap !== 1'b0) begin testsFailed++; $display("[TB] FAIL trap_pulse: got %b expected 0", trap); end
      end
`else
      if (c == 0) begin
        testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd9 || rfWdata !== 32'hA1B2_C3D4) begin testsFailed++; $display("[TB] FAIL align_lw: got %b %0d %h expected 1 9 a1b2c3d4", rfWe, rfWaddr, rfWdata); end
      end else if (c == 1) begin
        testsRun++; if (rfWe !== 1'b1 || rfWaddr !== 5'd11 || rfWdata !== 32'hFFFF_C3D4) begin testsFailed++; $display("[TB] FAIL align_lh: got %b %0d %h expected 1 11 ffffc3d4", rfWe, rfWaddr, rfWdata); end
      end else begin
        testsRun++; if (rfWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL align_idle: got %b expected 0", rfWe); end
      end
`endif
    end
  endtask

  task automatic test_random();
    entry_t e;
    logic stallV, flushV, rstV, expH;
    logic [31:0] dout;
    dout = $urandom;
    for (int n = 0; n < 600; n++) begin
      rstV = ($urandom % 100) == 0;
      flushV = ($urandom % 32) == 0;
      stallV = ($urandom % 5) == 0;
      e.valid = ($urandom % 4) != 0;
      e.pc = $urandom & 32'hFFFF_FFFC;
      e.alu = $urandom;
      e.rd = 5'($urandom_range(0, 7));
      e.regwen = 1'($urandom);
      e.ldsel = 3'($urandom);
      e.wbsel = 2'($urandom);
      if (!stallV) dout = $urandom;
      hazardRd = 5'($urandom_range(0, 7));
      applyStimulus(e, stallV, flushV, rstV, dout);
      testsRun++; if (rfWe !== expWe) begin testsFailed++; $display("[TB] FAIL rand_we_%0d: got %b expected %b", n, rfWe, expWe); end
      if (expWbValid) begin
        testsRun++; if (rfWaddr !== expWaddr || rfWdata !== expWdata) begin testsFailed++; $display("[TB] FAIL rand_data_%0d: got %0d %h expected %0d %h", n, rfWaddr, rfWdata, expWaddr, expWdata); end
      end
      expH = refHazard(hazardRd);
      testsRun++; if (hazard !== expH) begin testsFailed++; $display("[TB] FAIL rand_hazard_%0d: got %b expected %b", n, hazard, expH); end
`ifdef WB_MISALIGN_TRAP_EN
      testsRun++; if (trap !== expTrap || (expTrap && trapPc !== expTrapPc)) begin testsFailed++; $display("[TB] FAIL rand_trap_%0d: got %b %h expected %b %h", n, trap, trapPc, expTrap, expTrapPc); end
`endif
    end
  endtask

  task automatic test_dwidth64();
    localparam int N = 8;
    logic [2:0]  sels[N] = '{3'd6, 3'd2, 3'd3, 3'd0, 3'd5, 3'd1, 3'd0, 3'd2};
    logic [1:0]  wbs[N]  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1};
    logic [63:0] alus[N] = '{64'h1004, 64'h2004, 64'h3000, 64'h4007, 64'h5006, 64'h6002, 64'h0, 64'h7000};
    logic [63:0] douts[N] = '{64'h8000_0001_0000_0000, 64'h8000_0001_0000_0000, 64'h0123_4567_89AB_CDEF,
                              64'h8000_0000_0000_0000, 64'hBEEF_0000_0000_0000, 64'h0000_0000_8001_0000,
                              64'h0, 64'hFFFF_FFFF_7FFF_FFFF};
    logic [63:0] exps[N] = '{64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001, 64'h0123_4567_89AB_CDEF,
                             64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_BEEF, 64'hFFFF_FFFF_FFFF_8001,
                             64'h0, 64'h0000_0000_7FFF_FFFF};
    d64Rst = 1'b1; d64Stall = 1'b0; d64Flush = 1'b0; d64Valid = 1'b0; d64Pc = '0; d64Alu = '0;
    d64Rd = '0; d64Regwen = 1'b0; d64Ldsel = '0; d64Wbsel = '0; d64Dout = '0; d64HazardRd = 5'd0;
    @(posedge clk); #1;
    testsRun++; if (d64We !== 1'b0 || d64Wdata !== 64'h0) begin testsFailed++; $display("[TB] FAIL d64_reset: got %b %h expected 0 0", d64We, d64Wdata); end
    d64Rst = 1'b0;
    for (int i = 0; i <= N; i++) begin
      d64Valid = (i < N);
      if (i < N) begin
        d64Pc = (i == 6) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h100 + 64'(4 * i);
        d64Alu = alus[i]; d64Rd = 5'(i + 1); d64Regwen = 1'b1; d64Ldsel = sels[i]; d64Wbsel = wbs[i];
      end
      d64Dout = (i > 0) ? douts[i-1] : 64'h0;
      @(posedge clk); #1;
      if (i > 0) begin
        testsRun++; if (d64We !== 1'b1 || d64Waddr !== 5'(i) || d64Wdata !== exps[i-1]) begin testsFailed++; $display("[TB] FAIL d64_case%0d: got %b %0d %h expected 1 %0d %h", i - 1, d64We, d64Waddr, d64Wdata, i, exps[i-1]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_back_to_back();
    test_stall_flush();
    test_corner();
    test_misalign();
    test_random();
    test_dwidth64();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
